wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline write-back
//  (output of the write-back select mux) and a variable-latency unit (load/mul-div response).

---
 rtl/wb_port_arbiter_if.sv | 34 +++
 rtl/wb_port_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for the write-back port arbiter: pipeline WB request, unit result
// handshake, hazard lookup and the register-file write port.
interface wb_port_arbiter_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              pipe_wr_en;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_wdata;
  logic              pipe_stall;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_rd;
  logic [DATA_W-1:0] lu_wdata;
  logic [ADDR_W-1:0] chk_rd;
  logic              chk_hit;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  pipe_wr_en, pipe_rd, pipe_wdata, lu_valid, lu_rd, lu_wdata, chk_rd,
    output pipe_stall, lu_ready, chk_hit, rf_we, rf_waddr, rf_wdata, fifo_count
  );

  modport master (
    output pipe_wr_en, pipe_rd, pipe_wdata, lu_valid, lu_rd, lu_wdata, chk_rd,
    input  pipe_stall, lu_ready, chk_hit, rf_we, rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline write-back (priority) and a
// variable-latency unit whose results queue in a small FIFO with a starvation guard.
module wb_port_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ST_W  = $clog2(STARVE_LIMIT) + 1;

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ST_W-1:0]   starve_q, starve_d;
    logic [ADDR_W-1:0] rd_mem_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

    logic              accept, push, pop, bypass, stall;
    logic              sel_vld, hit;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              lu_ready_int;

    assign lu_ready_int = (count_q < CNT_W'(FIFO_DEPTH));
    assign accept       = bus.lu_valid & lu_ready_int;

    always_comb begin
        sel_vld  = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        pop      = 1'b0;
        bypass   = 1'b0;
        stall    = 1'b0;
        if (state_q == FORCE) begin
            sel_vld  = 1'b1;
            sel_rd   = rd_mem_q[rd_ptr_q];
            sel_data = data_mem_q[rd_ptr_q];
            pop      = 1'b1;
            stall    = 1'b1;
        end else if (bus.pipe_wr_en) begin
            sel_vld  = 1'b1;
            sel_rd   = bus.pipe_rd;
            sel_data = bus.pipe_wdata;
        end else if (count_q != '0) begin
            sel_vld  = 1'b1;
            sel_rd   = rd_mem_q[rd_ptr_q];
            sel_data = data_mem_q[rd_ptr_q];
            pop      = 1'b1;
        end else if (accept) begin
            sel_vld  = 1'b1;
            sel_rd   = bus.lu_rd;
            sel_data = bus.lu_wdata;
            bypass   = 1'b1;
        end
    end

    // x0 results are accepted but never stored
    assign push     = accept & ~bypass & (bus.lu_rd != '0);
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (pop || state_q == IDLE)
            starve_d = '0;
        else if (state_q == PEND && starve_q < ST_W'(STARVE_LIMIT - 1))
            starve_d = starve_q + 1'b1;

        case (state_q)
            IDLE:    if (push) state_d = PEND;
            PEND: begin
                if (count_d == '0)
                    state_d = IDLE;
                else if (!pop && starve_q == ST_W'(STARVE_LIMIT - 1))
                    state_d = FORCE;
            end
            FORCE:   state_d = (count_d != '0) ? PEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (CNT_W'(i) < count_q && rd_mem_q[rd_ptr_q + PTR_W'(i)] == bus.chk_rd)
                hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= bus.lu_rd;
            data_mem_q[wr_ptr_q] <= bus.lu_wdata;
        end
    end

    // Outputs are gated by rst_n so they read zero while reset is asserted
    assign bus.rf_we      = rst_n & sel_vld & (sel_rd != '0);
    assign bus.rf_waddr   = rst_n ? sel_rd : '0;
    assign bus.rf_wdata   = rst_n ? sel_data : '0;
    assign bus.pipe_stall = rst_n & stall;
    assign bus.lu_ready   = rst_n & lu_ready_int;
    assign bus.chk_hit    = rst_n & hit & (bus.chk_rd != '0);
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DATA_W=32, ADDR_W=5, FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) bus ();

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_wr_en = 1'b0; bus.pipe_rd = '0; bus.pipe_wdata = '0;
    bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_wdata = '0; bus.chk_rd = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_wdata = 32'hAA;
    #3;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0h want 0", bus.rf_we); end
    n_checks++; if (bus.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL rst_waddr: got %0h want 0", bus.rf_waddr); end
    n_checks++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0h want 0", bus.lu_ready); end
    n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL rst_count: got %0h want 0", bus.fifo_count); end
    tick(); tick();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %0h want 1", bus.lu_ready); end
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL post_rst_we: got %0h want 0", bus.rf_we); end
    tick();
  endtask

  task automatic test_bypass();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_wdata = 32'hAA; bus.chk_rd = 5'd7;
    #1;
    n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL byp_we: got %0h want 1", bus.rf_we); end
    n_checks++; if (bus.rf_waddr !== 5'd7) begin n_fail++; $display("FAIL byp_waddr: got %0h want 7", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'hAA) begin n_fail++; $display("FAIL byp_wdata: got %0h want aa", bus.rf_wdata); end
    n_checks++; if (bus.chk_hit !== 1'b0) begin n_fail++; $display("FAIL byp_hit: got %0h want 0", bus.chk_hit); end
    tick();
    idle_inputs();
    n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL byp_count: got %0h want 0", bus.fifo_count); end
  endtask

  task automatic test_priority();
    bus.pipe_wr_en = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_wdata = 32'h33;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_wdata = 32'h55;
    #1;
    n_checks++; if (bus.rf_waddr !== 5'd3) begin n_fail++; $display("FAIL pri_waddr: got %0h want 3", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'h33) begin n_fail++; $display("FAIL pri_wdata: got %0h want 33", bus.rf_wdata); end
    n_checks++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL pri_ready: got %0h want 1", bus.lu_ready); end
    tick();
    idle_inputs();
    bus.chk_rd = 5'd9;
    #1;
    n_checks++; if (bus.fifo_count !== 2'd1) begin n_fail++; $display("FAIL pri_count1: got %0h want 1", bus.fifo_count); end
    n_checks++; if (bus.chk_hit !== 1'b1) begin n_fail++; $display("FAIL pri_hit: got %0h want 1", bus.chk_hit); end
    n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL drain_we: got %0h want 1", bus.rf_we); end
    n_checks++; if (bus.rf_waddr !== 5'd9) begin n_fail++; $display("FAIL drain_waddr: got %0h want 9", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'h55) begin n_fail++; $display("FAIL drain_wdata: got %0h want 55", bus.rf_wdata); end
    tick();
    n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL drain_count: got %0h want 0", bus.fifo_count); end
    n_checks++; if (bus.chk_hit !== 1'b0) begin n_fail++; $display("FAIL drain_hit: got %0h want 0", bus.chk_hit); end
    idle_inputs();
  endtask

  task automatic test_full();
    bus.pipe_wr_en = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_wdata = 32'h11;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd10; bus.lu_wdata = 32'hA0;
    tick();
    bus.lu_rd = 5'd11; bus.lu_wdata = 32'hB0;
    #1;
    n_checks++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready2: got %0h want 1", bus.lu_ready); end
    tick();
    bus.lu_rd = 5'd12; bus.lu_wdata = 32'hC0;
    #1;
    n_checks++; if (bus.fifo_count !== 2'd2) begin n_fail++; $display("FAIL full_count2: got %0h want 2", bus.fifo_count); end
    n_checks++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready3: got %0h want 0", bus.lu_ready); end
    tick();
    n_checks++; if (bus.fifo_count !== 2'd2) begin n_fail++; $display("FAIL full_hold: got %0h want 2", bus.fifo_count); end
    bus.pipe_wr_en = 1'b0;
    #1;
    n_checks++; if (bus.rf_waddr !== 5'd10) begin n_fail++; $display("FAIL full_head1: got %0h want a", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'hA0) begin n_fail++; $display("FAIL full_data1: got %0h want a0", bus.rf_wdata); end
    n_checks++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_pop: got %0h want 0", bus.lu_ready); end
    tick();
    #1;
    n_checks++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_free: got %0h want 1", bus.lu_ready); end
    n_checks++; if (bus.rf_waddr !== 5'd11) begin n_fail++; $display("FAIL full_head2: got %0h want b", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'hB0) begin n_fail++; $display("FAIL full_data2: got %0h want b0", bus.rf_wdata); end
    tick();
    bus.lu_valid = 1'b0; bus.chk_rd = 5'd12;
    #1;
    n_checks++; if (bus.fifo_count !== 2'd1) begin n_fail++; $display("FAIL full_pushpop: got %0h want 1", bus.fifo_count); end
    n_checks++; if (bus.chk_hit !== 1'b1) begin n_fail++; $display("FAIL full_hit12: got %0h want 1", bus.chk_hit); end
    n_checks++; if (bus.rf_waddr !== 5'd12) begin n_fail++; $display("FAIL full_head3: got %0h want c", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'hC0) begin n_fail++; $display("FAIL full_data3: got %0h want c0", bus.rf_wdata); end
    tick();
    n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL full_empty: got %0h want 0", bus.fifo_count); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    bus.pipe_wr_en = 1'b1; bus.pipe_rd = 5'd2; bus.pipe_wdata = 32'h22;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd5; bus.lu_wdata = 32'h5A;
    tick();
    bus.lu_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_checks++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL starve_nostall c%0d: got %0h want 0", k, bus.pipe_stall); end
      n_checks++; if (bus.rf_waddr !== 5'd2) begin n_fail++; $display("FAIL starve_pipe c%0d: got %0h want 2", k, bus.rf_waddr); end
      tick();
    end
    #1;
    n_checks++; if (bus.pipe_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %0h want 1", bus.pipe_stall); end
    n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL starve_we: got %0h want 1", bus.rf_we); end
    n_checks++; if (bus.rf_waddr !== 5'd5) begin n_fail++; $display("FAIL starve_waddr: got %0h want 5", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 32'h5A) begin n_fail++; $display("FAIL starve_wdata: got %0h want 5a", bus.rf_wdata); end
    tick();
    n_checks++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL retry_stall: got %0h want 0", bus.pipe_stall); end
    n_checks++; if (bus.rf_waddr !== 5'd2) begin n_fail++; $display("FAIL retry_waddr: got %0h want 2", bus.rf_waddr); end
    n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL retry_count: got %0h want 0", bus.fifo_count); end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0_reset();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_wdata = 32'hFF;
    #1;
    n_checks++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0h want 1", bus.lu_ready); end
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_byp_we: got %0h want 0", bus.rf_we); end
    tick();
    bus.pipe_wr_en = 1'b1; bus.pipe_rd = 5'd4; bus.pipe_wdata = 32'h44;
    tick();
    n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL x0_drop: got %0h want 0", bus.fifo_count); end
    bus.lu_rd = 5'd13; bus.lu_wdata = 32'hD0;
    tick();
    bus.lu_rd = 5'd14; bus.lu_wdata = 32'hE0;
    tick();
    bus.lu_valid = 1'b0; bus.chk_rd = 5'd13;
    tick(); tick(); tick();
    n_checks++; if (bus.pipe_stall !== 1'b1) begin n_fail++; $display("FAIL pre_rst_stall: got %0h want 1", bus.pipe_stall); end
    n_checks++; if (bus.fifo_count !== 2'd2) begin n_fail++; $display("FAIL pre_rst_count: got %0h want 2", bus.fifo_count); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL arst_count: got %0h want 0", bus.fifo_count); end
    n_checks++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL arst_stall: got %0h want 0", bus.pipe_stall); end
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL arst_we: got %0h want 0", bus.rf_we); end
    n_checks++; if (bus.rf_wdata !== 32'h0) begin n_fail++; $display("FAIL arst_wdata: got %0h want 0", bus.rf_wdata); end
    n_checks++; if (bus.chk_hit !== 1'b0) begin n_fail++; $display("FAIL arst_hit: got %0h want 0", bus.chk_hit); end
    n_checks++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %0h want 0", bus.lu_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.chk_hit !== 1'b0) begin n_fail++; $display("FAIL post_arst_hit: got %0h want 0", bus.chk_hit); end
    n_checks++; if (bus.rf_waddr !== 5'd4) begin n_fail++; $display("FAIL post_arst_pipe: got %0h want 4", bus.rf_waddr); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_priority();
    test_full();
    test_starvation();
    test_x0_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
